// File: rtl/rgmii_rx_decoder_if.sv
// Byte stream leaving the RGMII receive decoder.
// No backpressure: the sink must take every tvalid beat.
interface rgmii_rx_decoder_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, tvalid, tlast, tuser);
  modport slave  (input  tdata, tvalid, tlast, tuser);
endinterface

// File: rtl/rgmii_rx_decoder.sv
// RGMII receive sequencer: DV/ER decode, preamble strip, byte assembly.
// Define RGMII_RX_INBAND_STATUS_EN to track PHY in-band link status.
module rgmii_rx_decoder #(
  parameter int STATUS_STABLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          input_q1,
  input  logic [4:0]          input_q2,
  input  logic [1:0]          mode_speed,
  rgmii_rx_decoder_if.master  output_rx,
  output logic                status_link_up,
  output logic [1:0]          status_speed,
  output logic                status_full_duplex,
  output logic                status_preamble_error,
  output logic                status_odd_nibble
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PREAMBLE = 2'd1;
  localparam logic [1:0] DATA     = 2'd2;
  localparam logic [1:0] DROP     = 2'd3;

  if (STATUS_STABLE_CYCLES < 1) begin : g_param_chk
    $error("STATUS_STABLE_CYCLES must be at least 1");
  end

  logic [4:0] q1_r, q2_r;
  logic       q_vld;
  logic       armed;
  logic [1:0] state;
  logic [1:0] spd_frame;
  logic       err;
  logic       phase;
  logic [3:0] lo;
  logic [7:0] stg;
  logic       stg_vld;
  logic       dv, er, gig;
  logic [7:0] byte_g;

  assign dv     = q1_r[4];
  assign er     = q1_r[4] ^ q2_r[4];
  assign gig    = spd_frame[1];
  assign byte_g = {q2_r[3:0], q1_r[3:0]};

  // armed stays low after reset until dv=0 is seen, so a frame
  // already in flight when reset drops is never picked up mid-way
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q1_r                  <= '0;
      q2_r                  <= '0;
      q_vld                 <= 1'b0;
      armed                 <= 1'b0;
      state                 <= IDLE;
      spd_frame             <= 2'b10;
      err                   <= 1'b0;
      phase                 <= 1'b0;
      lo                    <= '0;
      stg                   <= '0;
      stg_vld               <= 1'b0;
      output_rx.tdata       <= '0;
      output_rx.tvalid      <= 1'b0;
      output_rx.tlast       <= 1'b0;
      output_rx.tuser       <= 1'b0;
      status_preamble_error <= 1'b0;
      status_odd_nibble     <= 1'b0;
    end else begin
      q1_r                  <= input_q1;
      q2_r                  <= input_q2;
      q_vld                 <= 1'b1;
      output_rx.tvalid      <= 1'b0;
      output_rx.tlast       <= 1'b0;
      output_rx.tuser       <= 1'b0;
      status_preamble_error <= 1'b0;
      status_odd_nibble     <= 1'b0;
      unique case (state)
        IDLE: begin
          spd_frame <= status_speed;
          if (q_vld && !dv)
            armed <= 1'b1;
          if (dv && armed) begin
            state   <= PREAMBLE;
            err     <= 1'b0;
            phase   <= 1'b0;
            stg_vld <= 1'b0;
          end
        end
        PREAMBLE: begin
          if (!dv) begin
            state <= IDLE;
          end else if (gig) begin
            if (byte_g == 8'hD5) begin
              state <= DATA;
            end else if (byte_g != 8'h55) begin
              state                 <= DROP;
              status_preamble_error <= 1'b1;
            end
          end else begin
            if (q1_r[3:0] == 4'hD) begin
              state <= DATA;
            end else if (q1_r[3:0] != 4'h5) begin
              state                 <= DROP;
              status_preamble_error <= 1'b1;
            end
          end
        end
        DATA: begin
          if (dv) begin
            if (er)
              err <= 1'b1;
            if (gig || phase) begin
              stg     <= gig ? byte_g : {q1_r[3:0], lo};
              stg_vld <= 1'b1;
              phase   <= 1'b0;
              if (stg_vld) begin
                output_rx.tvalid <= 1'b1;
                output_rx.tdata  <= stg;
              end
            end else begin
              lo    <= q1_r[3:0];
              phase <= 1'b1;
            end
          end else begin
            state             <= IDLE;
            stg_vld           <= 1'b0;
            phase             <= 1'b0;
            status_odd_nibble <= phase;
            if (stg_vld) begin
              output_rx.tvalid <= 1'b1;
              output_rx.tdata  <= stg;
              output_rx.tlast  <= 1'b1;
              output_rx.tuser  <= err | phase;
            end
          end
        end
        DROP: begin
          if (!dv)
            state <= IDLE;
        end
      endcase
    end
  end

`ifdef RGMII_RX_INBAND_STATUS_EN
  localparam int CW = $clog2(STATUS_STABLE_CYCLES + 1);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    cand_r;
  logic          cand_ok;

  assign cand_ok = q_vld && state == IDLE && !dv && !er &&
                   (q1_r[3:0] == q2_r[3:0]);

  always_comb begin
    cnt_nxt = CW'(1);
    if (cnt != '0 && q1_r[3:0] == cand_r)
      cnt_nxt = (cnt == CW'(STATUS_STABLE_CYCLES)) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt                <= '0;
      cand_r             <= '0;
      status_link_up     <= 1'b0;
      status_full_duplex <= 1'b0;
      status_speed       <= 2'b10;
    end else if (cand_ok) begin
      cand_r <= q1_r[3:0];
      cnt    <= cnt_nxt;
      if (cnt_nxt == CW'(STATUS_STABLE_CYCLES)) begin
        status_full_duplex <= q1_r[3];
        status_speed       <= q1_r[2:1];
        status_link_up     <= q1_r[0];
      end
    end else begin
      cnt <= '0;
    end
  end
`else
  assign status_link_up     = 1'b0;
  assign status_full_duplex = 1'b0;
  assign status_speed       = (mode_speed == 2'b11) ? 2'b10 : mode_speed;
`endif

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// Scoreboard bench for rgmii_rx_decoder: directed frames at all speeds,
// preamble/odd-nibble errors, async reset mid-frame, in-band status.
module tb_rgmii_rx_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] q1, q2;
  logic [1:0] mode;
  logic       link, dup, pe, odd;
  logic [1:0] spd;

  rgmii_rx_decoder_if rx ();

  rgmii_rx_decoder #(.STATUS_STABLE_CYCLES(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .input_q1              (q1),
    .input_q2              (q2),
    .mode_speed            (mode),
    .output_rx             (rx),
    .status_link_up        (link),
    .status_speed          (spd),
    .status_full_duplex    (dup),
    .status_preamble_error (pe),
    .status_odd_nibble     (odd)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  int    n_pe   = 0;
  int    n_odd  = 0;
  bit    mon_en = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (pe)  n_pe++;
      if (odd) n_odd++;
      if (mon_en && rx.tvalid) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat got %h last=%b user=%b want none",
                   rx.tdata, rx.tlast, rx.tuser);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (rx.tdata !== e.d || rx.tlast !== e.l || rx.tuser !== e.u) begin
            n_fail++;
            $display("FAIL beat got %h/%b/%b want %h/%b/%b",
                     rx.tdata, rx.tlast, rx.tuser, e.d, e.l, e.u);
          end
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic drv(logic [4:0] a, logic [4:0] b);
    @(negedge clk);
    q1 = a;
    q2 = b;
  endtask

  task automatic gbyte(logic [7:0] d, logic e = 1'b0);
    drv({1'b1, d[3:0]}, {~e, d[7:4]});
  endtask

  task automatic nib(logic [3:0] n);
    drv({1'b1, n}, {1'b1, n});
  endtask

  task automatic idle(int n, logic [3:0] v);
    repeat (n) drv({1'b0, v}, {1'b0, v});
  endtask

  task automatic push(logic [7:0] d, logic l, logic u);
    beat_t b;
    b.d = d; b.l = l; b.u = u;
    exp_q.push_back(b);
  endtask

  task automatic set_speed(logic [1:0] s);
    mode = s;
    idle(6, {1'b1, s, 1'b1});
  endtask

  task automatic gpre();
    repeat (7) gbyte(8'h55);
    gbyte(8'hD5);
  endtask

  initial begin
    rst  = 1'b1;
    q1   = '0;
    q2   = '0;
    mode = 2'b10;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", rx.tvalid, 0);
    chk("rst_tlast",  rx.tlast,  0);
    chk("rst_tuser",  rx.tuser,  0);
    chk("rst_tdata",  rx.tdata,  0);
    chk("rst_pulses", {pe, odd}, 0);
    chk("rst_link",   {link, dup}, 0);
    chk("rst_speed",  spd, 2'b10);
    rst    = 1'b0;
    mon_en = 1'b1;

    // 1000: 64-byte frame
    set_speed(2'b10);
    chk("speed_1000", spd, 2'b10);
    gpre();
    for (int i = 1; i <= 64; i++) begin
      push(8'(i), i == 64, 1'b0);
      gbyte(8'(i));
    end
    set_speed(2'b10);

    // 100: two bytes as nibbles
    set_speed(2'b01);
    chk("speed_100", spd, 2'b01);
    repeat (15) nib(4'h5);
    nib(4'hD);
    push(8'hA7, 1'b0, 1'b0);
    push(8'h3C, 1'b1, 1'b0);
    nib(4'h7); nib(4'hA); nib(4'hC); nib(4'h3);
    set_speed(2'b01);

    // 1000: er on byte 10 of 20
    set_speed(2'b10);
    gpre();
    for (int i = 0; i < 20; i++) begin
      push(8'h80 + 8'(i), i == 19, i == 19);
      gbyte(8'h80 + 8'(i), i == 9);
    end
    set_speed(2'b10);

    // 10: three data nibbles -> odd nibble
    set_speed(2'b00);
    chk("speed_10", spd, 2'b00);
    repeat (15) nib(4'h5);
    nib(4'hD);
    push(8'h21, 1'b1, 1'b1);
    nib(4'h1); nib(4'h2); nib(4'h3);
    set_speed(2'b00);
    chk("odd_pulses", n_odd, 1);

    // bad preamble then a good frame
    set_speed(2'b10);
    gbyte(8'h55); gbyte(8'h57); gbyte(8'h11); gbyte(8'h22);
    set_speed(2'b10);
    chk("pre_pulses", n_pe, 1);
    gbyte(8'h55); gbyte(8'h55); gbyte(8'hD5);
    push(8'hDE, 1'b0, 1'b0);
    push(8'hAD, 1'b1, 1'b0);
    gbyte(8'hDE); gbyte(8'hAD);
    set_speed(2'b10);

`ifdef RGMII_RX_INBAND_STATUS_EN
    idle(6, 4'h0);
    chk("ib_link0",  link, 0);
    chk("ib_speed0", spd, 2'b00);
    chk("ib_dup0",   dup, 0);
    idle(1, 4'hD);
    idle(4, 4'h0);
    chk("ib_single_d", {link, spd, dup}, 4'b0000);
    idle(2, 4'hD);
    idle(1, 4'h0);
    for (int i = 0; i < 4; i++) begin
      idle(1, 4'hD);
      chk("ib_after_glitch", {link, spd, dup}, 4'b1101);
    end
`else
    mode = 2'b11;
    @(negedge clk);
    chk("speed_11_map", spd, 2'b10);
    set_speed(2'b10);
`endif

    // async reset mid-frame, then frame in progress must be ignored
    mon_en = 1'b0;
    gpre();
    for (int i = 0; i < 5; i++) gbyte(8'h30 + 8'(i));
    #2 rst = 1'b1;
    #1;
    chk("arst_tvalid", rx.tvalid, 0);
    chk("arst_tlast",  rx.tlast,  0);
    chk("arst_tuser",  rx.tuser,  0);
    chk("arst_tdata",  rx.tdata,  0);
    chk("arst_link",   link, 0);
    gbyte(8'h55); gbyte(8'h55);
    rst    = 1'b0;
    mon_en = 1'b1;
    gbyte(8'h55); gbyte(8'hD5);
    for (int i = 0; i < 8; i++) gbyte(8'h40 + 8'(i));
    set_speed(2'b10);
    gpre();
    push(8'hC1, 1'b0, 1'b0);
    push(8'hC2, 1'b0, 1'b0);
    push(8'hC3, 1'b1, 1'b0);
    gbyte(8'hC1); gbyte(8'hC2); gbyte(8'hC3);
    set_speed(2'b10);

    begin
      int w = 0;
      while (exp_q.size() != 0 && w < 100) begin
        @(negedge clk);
        w++;
      end
    end
    chk("drain", exp_q.size(), 0);
    chk("pre_pulses_end", n_pe, 1);
    chk("odd_pulses_end", n_odd, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
